// File: rtl/oled_colours_pkg.sv
// rtl/oled_colours_pkg.sv - RGB565 colour constants, palette and screen FSM encodings
package oled_colours_pkg;

  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] ORANGE  = 16'hFC00;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] BROWN   = 16'h8204;
  localparam logic [15:0] SKYBLUE = 16'h5FFF;

  localparam logic [15:0] PALETTE [0:7] = '{GREEN, YELLOW, RED, CYAN, BLUE, MAGENTA, ORANGE, WHITE};

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_CYCLE = 2'd1,
    MODE_WIPE  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [15:0] palette_colour(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/game_screen_anim_if.sv
// rtl/game_screen_anim_if.sv - control, pixel-address and pixel-data bundle of the animated game screen
interface game_screen_anim_if;
  logic        frame_begin;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled_data;
  logic        busy;
  logic        done;

  modport master (
    output frame_begin, start, abort, mode, x, y,
    input  oled_data, busy, done
  );

  modport slave (
    input  frame_begin, start, abort, mode, x, y,
    output oled_data, busy, done
  );
endinterface

// File: rtl/screen_pixel_sel.sv
// rtl/screen_pixel_sel.sv - combinational colour lookup for one (x, y) given the animation state
module screen_pixel_sel
  import oled_colours_pkg::*;
#(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 64,
  parameter int NUM_COLOURS = 4,
  parameter int BORDER      = 2,
  parameter int ST_W        = 3,
  parameter int WR_W        = 7
) (
  input  state_e            state,
  input  mode_e             mode,
  input  logic [ST_W-1:0]   step,
  input  logic              phase,
  input  logic [WR_W-1:0]   wipe_row,
  input  logic [6:0]        x,
  input  logic [5:0]        y,
  output logic [15:0]       colour
);

  localparam logic [7:0] W8 = 8'(WIDTH);
  localparam logic [7:0] H8 = 8'(HEIGHT);
  localparam logic [7:0] B8 = 8'(BORDER);
  localparam logic [2:0] INTERIOR_IDX = 3'(2 % NUM_COLOURS);

  logic [7:0] x_e, y_e, row_e;
  logic       in_range, border;

  always_comb begin
    x_e      = {1'b0, x};
    y_e      = {2'b00, y};
    row_e    = 8'(wipe_row);
    in_range = (x_e < W8) && (y_e < H8);
    border   = (x_e < B8) || (x_e >= W8 - B8) || (y_e < B8) || (y_e >= H8 - B8);
    colour   = BLACK;
    if (in_range && state != ST_IDLE) begin
      case (mode)
        MODE_SOLID: colour = palette_colour(3'd0);
        MODE_CYCLE: colour = palette_colour(3'(step));
        MODE_WIPE:  colour = (y_e < row_e) ? palette_colour(3'd0) : BLACK;
        default:    colour = border ? palette_colour({2'b00, phase}) : palette_colour(INTERIOR_IDX);
      endcase
    end
  end

endmodule

// File: rtl/game_screen_anim.sv
// rtl/game_screen_anim.sv - animated game screen: IDLE/RUN/HOLD FSM, frame/step counters, registered pixel
module game_screen_anim
  import oled_colours_pkg::*;
#(
  parameter int WIDTH           = 96,
  parameter int HEIGHT          = 64,
  parameter int NUM_COLOURS     = 4,
  parameter int FRAMES_PER_STEP = 15,
  parameter int BORDER          = 2
) (
  input  logic               clk,
  input  logic               reset,
  game_screen_anim_if.slave  bus
);

  localparam int FC_W = $clog2(FRAMES_PER_STEP + 1);
  localparam int ST_W = $clog2(NUM_COLOURS + 1);
  localparam int WR_W = $clog2(HEIGHT + 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [ST_W-1:0]   step_q, step_d;
  logic [WR_W-1:0]   wipe_row_q, wipe_row_d;
  logic              phase_q, phase_d;
  logic [15:0]       oled_data_q, oled_data_d;
  logic              done_q, done_d;
  logic              step_evt;
  logic [15:0]       pix_colour;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_SOLID;
      frame_cnt_q <= '0;
      step_q      <= '0;
      wipe_row_q  <= '0;
      phase_q     <= 1'b0;
      oled_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
      wipe_row_q  <= wipe_row_d;
      phase_q     <= phase_d;
      oled_data_q <= oled_data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    step_d      = step_q;
    wipe_row_d  = wipe_row_q;
    phase_d     = phase_q;
    step_evt    = bus.frame_begin && (frame_cnt_q == FC_W'(FRAMES_PER_STEP - 1));
    // abort beats start, and start swallows a coincident frame pulse
    if (bus.abort || bus.start) begin
      state_d     = bus.abort ? ST_IDLE : ST_RUN;
      mode_d      = bus.abort ? mode_q : mode_e'(bus.mode);
      frame_cnt_d = '0;
      step_d      = '0;
      wipe_row_d  = '0;
      phase_d     = 1'b0;
    end else if (state_q == ST_RUN) begin
      case (mode_q)
        MODE_SOLID: state_d = ST_HOLD;
        MODE_WIPE: begin
          if (bus.frame_begin) begin
            wipe_row_d = wipe_row_q + WR_W'(1);
            if (wipe_row_q == WR_W'(HEIGHT - 1)) state_d = ST_HOLD;
          end
        end
        default: begin
          if (bus.frame_begin) frame_cnt_d = step_evt ? '0 : frame_cnt_q + FC_W'(1);
          if (step_evt) begin
            if (mode_q == MODE_BLINK) phase_d = ~phase_q;
            else if (step_q == ST_W'(NUM_COLOURS - 1)) state_d = ST_HOLD;
            else step_d = step_q + ST_W'(1);
          end
        end
      endcase
    end
  end

  screen_pixel_sel #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_COLOURS(NUM_COLOURS),
    .BORDER(BORDER), .ST_W(ST_W), .WR_W(WR_W)
  ) u_pixel_sel (
    .state(state_q), .mode(mode_q), .step(step_q), .phase(phase_q),
    .wipe_row(wipe_row_q), .x(bus.x), .y(bus.y), .colour(pix_colour)
  );

  always_comb begin
    oled_data_d = pix_colour;
    done_d      = (state_d == ST_HOLD) && (state_q != ST_HOLD);
  end

  assign bus.oled_data = oled_data_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_game_screen_anim.sv
// tb/tb_game_screen_anim.sv - directed plus random stimulus against a frame-count reference model
module tb_game_screen_anim;

  localparam int W   = 96;
  localparam int H   = 64;
  localparam int NC  = 4;
  localparam int FPS = 2;
  localparam int B   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_screen_anim_if bus ();

  game_screen_anim #(
    .WIDTH(W), .HEIGHT(H), .NUM_COLOURS(NC), .FRAMES_PER_STEP(FPS), .BORDER(B)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  logic [15:0] pal [8] = '{16'h07E0, 16'hFFE0, 16'hF800, 16'h07FF,
                           16'h001F, 16'hF81F, 16'hFC00, 16'hFFFF};

  int tests = 0;
  int fails = 0;

  // model: 0 idle, 1 running, 2 holding; frames = frame pulses seen since start
  int m_state = 0;
  int m_mode = 0;
  int m_frames = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int st, input int md, input int fr,
                                           input int xx, input int yy);
    int idx;
    bit brd;
    if (st == 0 || xx >= W || yy >= H) return 16'h0000;
    case (md)
      0: return pal[0];
      1: begin
        idx = fr / FPS;
        if (idx > NC - 1) idx = NC - 1;
        return pal[idx];
      end
      2: return (yy < ((fr < H) ? fr : H)) ? pal[0] : 16'h0000;
      default: begin
        brd = (xx < B) || (xx >= W - B) || (yy < B) || (yy >= H - B);
        return brd ? pal[(fr / FPS) % 2] : pal[2 % NC];
      end
    endcase
  endfunction

  task automatic tick(input bit fb, input bit st, input bit ab, input int md,
                      input int xx, input int yy);
    logic [15:0] ep;
    int prev;
    bit ed, eb;
    bus.frame_begin = fb;
    bus.start = st;
    bus.abort = ab;
    bus.mode = 2'(md);
    bus.x = 7'(xx);
    bus.y = 6'(yy);
    ep = exp_pix(m_state, m_mode, m_frames, xx, yy);
    prev = m_state;
    if (ab) begin
      m_state = 0;
      m_frames = 0;
    end else if (st) begin
      m_state = 1;
      m_mode = md;
      m_frames = 0;
    end else if (m_state == 1) begin
      if (m_mode == 0) m_state = 2;
      else if (fb) begin
        m_frames++;
        if (m_mode == 1 && m_frames == FPS * NC) m_state = 2;
        if (m_mode == 2 && m_frames == H) m_state = 2;
      end
    end
    ed = (m_state == 2) && (prev != 2);
    eb = (m_state == 1);
    @(posedge clk);
    #1;
    chk("pix", bus.oled_data, ep);
    chk("busy", 16'(bus.busy), 16'(eb));
    chk("done", 16'(bus.done), 16'(ed));
    @(negedge clk);
  endtask

  task automatic rtick(input bit fb);
    tick(fb, 1'b0, 1'b0, 0, $urandom_range(0, 127), $urandom_range(0, 63));
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      rtick(1'b1);
      repeat ($urandom_range(0, 2)) rtick(1'b0);
    end
  endtask

  task automatic do_reset();
    bus.frame_begin = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_pix", bus.oled_data, 16'h0000);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    m_state = 0;
    m_mode = 0;
    m_frames = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.frame_begin = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode = 2'd0;
    bus.x = 7'd0;
    bus.y = 6'd0;
    @(negedge clk);
    do_reset();

    // idle is black, then SOLID
    repeat (4) rtick(1'b0);
    tick(1'b0, 1'b1, 1'b0, 0, 10, 10);
    tick(1'b0, 1'b0, 1'b0, 0, 10, 10);
    tick(1'b0, 1'b0, 1'b0, 0, 10, 10);
    tick(1'b0, 1'b0, 1'b0, 0, 100, 5);
    repeat (3) rtick(1'b1);

    // CYCLE through four colours, then hold
    tick(1'b0, 1'b1, 1'b0, 1, 20, 20);
    frames(8);
    repeat (4) rtick(1'b1);

    // WIPE: partial rows, then full
    tick(1'b0, 1'b1, 1'b0, 2, 0, 0);
    frames(10);
    tick(1'b0, 1'b0, 1'b0, 0, 0, 9);
    tick(1'b0, 1'b0, 1'b0, 0, 0, 10);
    frames(54);
    repeat (4) rtick(1'b1);

    // BLINK border/interior and phase toggling
    tick(1'b0, 1'b1, 1'b0, 3, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 0, 95, 63);
    tick(1'b0, 1'b0, 1'b0, 0, 1, 30);
    tick(1'b0, 1'b0, 1'b0, 0, 2, 30);
    frames(FPS);
    tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 0, 94, 40);
    frames(9);

    // start coincident with frame pulse, abort mid-CYCLE, abort beats start
    tick(1'b1, 1'b1, 1'b0, 1, 5, 5);
    tick(1'b0, 1'b0, 1'b0, 0, 5, 5);
    frames(3);
    tick(1'b0, 1'b0, 1'b1, 0, 5, 5);
    tick(1'b0, 1'b0, 1'b0, 0, 5, 5);
    tick(1'b0, 1'b1, 1'b1, 1, 5, 5);
    repeat (3) rtick(1'b1);

    // asynchronous reset mid-WIPE
    tick(1'b0, 1'b1, 1'b0, 2, 0, 0);
    frames(5);
    tick(1'b0, 1'b0, 1'b0, 0, 0, 1);
    do_reset();
    repeat (3) rtick(1'b1);

    // random soak
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      tick($urandom_range(0, 2) == 0, r < 3, (r >= 3) && (r < 5),
           $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 63));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_screen_anim.md
# game_screen_anim

Parametrised, animated successor to the fixed solid-colour game screens. It renders one OLED pixel per clock from (x, y) and adds four display modes: solid, timed palette cycle, top-down wipe and blinking border. Animation steps on the frame-begin pulse from the OLED driver. It sits between the game FSM (start/mode/abort) and the OLED pixel mux.

## Interface
Parameters:
- WIDTH, 96, screen width in pixels
- HEIGHT, 64, screen height in pixels
- NUM_COLOURS, 4, palette entries used (1..8), taken from the package palette in order
- FRAMES_PER_STEP, 15, frame_begin pulses per animation step (>=1)
- BORDER, 2, border thickness in pixels for BLINK mode

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_begin  in  1  one-cycle pulse at start of each OLED frame
- start  in  1  one-cycle pulse; latches mode and starts the animation
- abort  in  1  one-cycle pulse; return to IDLE
- mode  in  2  0 SOLID, 1 CYCLE, 2 WIPE, 3 BLINK; sampled only on start
- x  in  7  pixel column, 0..WIDTH-1
- y  in  6  pixel row, 0..HEIGHT-1
- oled_data  out  16  RGB565 pixel, registered
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on entry to HOLD

## Operation
- States: IDLE, RUN, HOLD. Reset gives IDLE, and all counters, oled_data, busy and done are 0.
- IDLE: output BLACK.
- Start in any state: latch mode, clear frame_cnt/step/wipe_row, go to RUN. Exception: SOLID goes directly to HOLD, and done fires next cycle.
- abort takes priority over start. It forces IDLE from any state. No done pulse.
- frame_cnt counts frame_begin pulses from 0 to FRAMES_PER_STEP-1, then wraps. The wrap is a step event.
- CYCLE: output PALETTE[step] on the full screen. On a step event, step increments. A step event with step==NUM_COLOURS-1 goes to HOLD, and the output stays PALETTE[NUM_COLOURS-1].
- WIPE: y < wipe_row shows PALETTE[0]; other pixels are BLACK. wipe_row increments on every frame_begin (frame_cnt unused). When wipe_row reaches HEIGHT, go to HOLD with the full screen PALETTE[0].
- BLINK: border pixels are x<BORDER, x>=WIDTH-BORDER, y<BORDER and y>=HEIGHT-BORDER. Border shows PALETTE[phase ? 1 : 0]. Interior shows PALETTE[2 mod NUM_COLOURS]. phase toggles on each step event. BLINK never reaches HOLD; it runs until start or abort.
- HOLD: freeze the final image. busy=0.
- Out-of-range x/y (x>=WIDTH or y>=HEIGHT) output BLACK in all states.
- Widths: frame_cnt is $clog2(FRAMES_PER_STEP+1), step is $clog2(NUM_COLOURS+1), wipe_row is $clog2(HEIGHT+1). Comparisons are unsigned. There is no wrap past the terminal values.

## Timing
- oled_data has 1-cycle latency: the value in cycle n+1 is the colour for the (x, y) sampled in cycle n and the state in cycle n.
- start in cycle n: busy=1 from n+1. The SOLID pixel is valid from n+2.
- A start and frame_begin in the same cycle: start wins and the frame pulse is ignored.
- The frame_begin that causes the terminal step moves to HOLD on the next edge. done is high for exactly that one cycle, and busy drops in the same cycle.
- A start in RUN or HOLD restarts cleanly. No done is issued for the interrupted run.
- Reset asserted mid-animation clears all state asynchronously. oled_data reads 0 immediately.

## Structure
- The shared package oled_colours_pkg holds:
  - RGB565 constants with correct values: BLACK 0000, WHITE FFFF, RED F800, GREEN 07E0, BLUE 001F, YELLOW FFE0, ORANGE FC00, CYAN 07FF, MAGENTA F81F, BROWN 8204, SKYBLUE 5FFF.
  - PALETTE[0:7] = GREEN, YELLOW, RED, CYAN, BLUE, MAGENTA, ORANGE, WHITE.
  - The mode and state encodings.
- One sub-module, screen_pixel_sel, is natural. It is combinational and maps (state, mode, step, phase, wipe_row, x, y) to a colour. The top level keeps the FSM, the counters and the output register.

## Test plan
- Reset, then mode=0 start → busy=1 for 1 cycle, done pulse; pixel (10,10) reads 07E0 two cycles after start; IDLE before start reads 0000.
- mode=1, FRAMES_PER_STEP=2, NUM_COLOURS=4, 8 frame pulses → colours 07E0, FFE0, F800, 07FF each for 2 frames; done on the 8th pulse; held at 07FF.
- mode=2, HEIGHT=64 → after 10 frames (0,9) reads 07E0 and (0,10) reads 0000; done after the 64th frame.
- mode=3, BORDER=2 → (0,0) and (95,63) read 07E0, (1,30) reads 07E0, (2,30) reads F800; after FRAMES_PER_STEP frames the border reads FFE0; done never pulses.
- start and frame_begin in the same cycle, abort mid-CYCLE, reset mid-WIPE → counters cleared, abort gives IDLE with 0000 and no done, reset gives oled_data 0000 asynchronously.
- x=100, y=5 in HOLD of SOLID → 0000.
